pwm_capture: RTL and testbench



---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_div.sv | 92 +++++++++
 rtl/pwm_capture.sv | 213 +++++++++++++++++++++
 tb/tb_pwm_capture.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and constants for the PWM capture block.
package pwm_pkg;

    // Capture FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    // Default counter width and its saturation ceiling.
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned CNT_MAX_DEF = (1 << CNT_W_DEF) - 1;

    // Pulse-per-burst counter width and ceiling.
    localparam int unsigned        BURST_W   = 8;
    localparam logic [BURST_W-1:0] BURST_MAX = '1;

    // Percent scaling: 100 fits in PCT_W bits; duty result is DUTY_W bits.
    localparam int unsigned PCT_FULL = 100;
    localparam int unsigned PCT_W    = 7;
    localparam int unsigned DUTY_W   = 8;

endpackage

// File: rtl/pwm_div.sv
// pwm_div: start/busy/done restoring divider, one quotient bit per cycle.
// A start while busy reloads the operands, so a stale quotient never
// reaches result_o. done_o pulses N_W+1 cycles after start_i.
module pwm_div #(
    parameter int unsigned N_W = 23,   // dividend width
    parameter int unsigned D_W = 16,   // divisor width
    parameter int unsigned R_W = 8     // reported quotient width
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [N_W-1:0] dividend_i,
    input  logic [D_W-1:0] divisor_i,
    output logic           done_o,
    output logic [R_W-1:0] result_o
);

    localparam int unsigned CNT_BITS = $clog2(N_W + 1);

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [D_W-1:0]      rem_q, rem_d;
    logic [D_W-1:0]      dvs_q, dvs_d;
    logic [N_W-1:0]      quot_q, quot_d;
    logic [R_W-1:0]      res_q, res_d;
    logic [D_W:0]        rem_sh;
    logic [D_W-1:0]      rem_sub;

    // Next-state: load on start, otherwise shift/subtract one bit while busy.
    always_comb begin
        // NOTE: every _d gets its default first; a path leaving one unassigned would infer a latch.
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        res_d   = res_q;
        // Remainder is always below the divisor, so it fits D_W bits before the shift.
        rem_sh  = {rem_q, quot_q[N_W-1]};
        rem_sub = rem_sh[D_W-1:0] - dvs_q;

        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CNT_BITS'(N_W);
            rem_d  = '0;
            quot_d = dividend_i;
            dvs_d  = divisor_i;
        end else if (busy_q) begin
            if (rem_sh >= {1'b0, dvs_q}) begin
                rem_d  = rem_sub;
                quot_d = {quot_q[N_W-2:0], 1'b1};
            end else begin
                rem_d  = rem_sh[D_W-1:0];
                quot_d = {quot_q[N_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_BITS'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                res_d  = quot_d[R_W-1:0];
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            quot_q <= '0;
            res_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quot_q <= quot_d;
            res_q  <= res_d;
        end
    end

    assign done_o   = done_q;
    assign result_o = res_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input, counts pulses
// per burst and flags burst end after an idle timeout.
// Optional build macro DUTY_PCT_EN adds a duty-percent divider (pwm_div);
// without it measDuty/dutyValid are tied low.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned SYNC_STAGES = 2          // 2..3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwmIn,
    input  logic               enable,
    output logic [CNT_W-1:0]   measPeriod,
    output logic [CNT_W-1:0]   measHigh,
    output logic               measValid,
    output logic [BURST_W-1:0] burstCount,
    output logic               burstDone,
    output logic [DUTY_W-1:0]  measDuty,
    output logic               dutyValid
);

    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pwm_s;
    logic                   rise;
    logic                   fall;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic [CNT_W-1:0]   low_q, low_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   mhigh_q, mhigh_d;
    logic [BURST_W-1:0] pulse_q, pulse_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic [CNT_W:0]     sum;
    logic [CNT_W-1:0]   period_sat;
    logic               timeout;

    // Input synchroniser plus one-flop edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwmIn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~prev_q;
    assign fall  = ~pwm_s & prev_q;

    // Period sum is one bit wider so overflow clamps instead of wrapping.
    assign sum        = {1'b0, high_q} + {1'b0, low_q};
    assign period_sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    assign timeout    = (idle_q == IDLE_LAST);

    // Next-state and strobe logic for the capture FSM.
    always_comb begin
        state_d  = state_q;
        high_d   = high_q;
        low_d    = low_q;
        pulse_d  = pulse_q;
        idle_d   = idle_q;
        period_d = period_q;
        mhigh_d  = mhigh_q;
        burst_d  = burst_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            high_d  = '0;
            low_d   = '0;
            pulse_d = '0;
            idle_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    high_d  = '0;
                    low_d   = '0;
                    pulse_d = '0;
                    idle_d  = '0;
                    // First edge of a burst: nothing to report yet.
                    if (rise) begin
                        state_d = ST_HIGH;
                        high_d  = CNT_W'(1);
                        pulse_d = BURST_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_d = ST_LOW;
                        low_d   = CNT_W'(1);
                        idle_d  = '0;
                    end else if (timeout) begin
                        // Partial period is dropped; only the pulse count is reported.
                        state_d = ST_IDLE;
                        burst_d = pulse_q;
                        done_d  = 1'b1;
                        high_d  = '0;
                        low_d   = '0;
                        pulse_d = '0;
                        idle_d  = '0;
                    end else begin
                        high_d = (&high_q) ? high_q : high_q + 1'b1;
                        idle_d = idle_q + 1'b1;
                    end
                end
                ST_LOW: begin
                    // A rise beats a simultaneous timeout.
                    if (rise) begin
                        state_d  = ST_HIGH;
                        period_d = period_sat;
                        mhigh_d  = high_q;
                        valid_d  = 1'b1;
                        high_d   = CNT_W'(1);
                        low_d    = '0;
                        pulse_d  = (pulse_q == BURST_MAX) ? pulse_q : pulse_q + 1'b1;
                        idle_d   = '0;
                    end else if (timeout) begin
                        state_d = ST_IDLE;
                        burst_d = pulse_q;
                        done_d  = 1'b1;
                        high_d  = '0;
                        low_d   = '0;
                        pulse_d = '0;
                        idle_d  = '0;
                    end else begin
                        low_d  = (&low_q) ? low_q : low_q + 1'b1;
                        idle_d = idle_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    high_d  = '0;
                    low_d   = '0;
                    pulse_d = '0;
                    idle_d  = '0;
                end
            endcase
        end
    end

    // FSM, counters and measurement output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            high_q   <= '0;
            low_q    <= '0;
            pulse_q  <= '0;
            idle_q   <= '0;
            period_q <= '0;
            mhigh_q  <= '0;
            burst_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            high_q   <= high_d;
            low_q    <= low_d;
            pulse_q  <= pulse_d;
            idle_q   <= idle_d;
            period_q <= period_d;
            mhigh_q  <= mhigh_d;
            burst_q  <= burst_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign measPeriod = period_q;
    assign measHigh   = mhigh_q;
    assign measValid  = valid_q;
    assign burstCount = burst_q;
    assign burstDone  = done_q;

`ifdef DUTY_PCT_EN
    // high*100 always fits CNT_W+PCT_W bits; high <= period keeps the quotient <= 100.
    logic [CNT_W+PCT_W-1:0] div_num;

    assign div_num = (CNT_W + PCT_W)'(mhigh_q) * (CNT_W + PCT_W)'(PCT_FULL);

    pwm_div #(
        .N_W (CNT_W + PCT_W),
        .D_W (CNT_W),
        .R_W (DUTY_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (valid_q),
        .dividend_i (div_num),
        .divisor_i  (period_q),
        .done_o     (dutyValid),
        .result_o   (measDuty)
    );
`else
    assign measDuty  = '0;
    assign dutyValid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table-driven bench with scoreboard queues for pwm_capture.
// CNT_W is reduced to 10 so period saturation (1023) is reachable with both
// phases shorter than TIMEOUT.
module tb_pwm_capture;

    localparam int unsigned CNT_W       = 10;
    localparam int unsigned TIMEOUT     = 1024;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned LAT         = SYNC_STAGES + 1;
    localparam int unsigned DIV_LAT     = CNT_W + 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic             enable;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_valid;
    logic [7:0]       burst_count;
    logic             burst_done;
    logic [7:0]       meas_duty;
    logic             duty_valid;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwmIn      (pwm_in),
        .enable     (enable),
        .measPeriod (meas_period),
        .measHigh   (meas_high),
        .measValid  (meas_valid),
        .burstCount (burst_count),
        .burstDone  (burst_done),
        .measDuty   (meas_duty),
        .dutyValid  (duty_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned hi_len;
        int unsigned lo_len;
        int unsigned exp_period;
        int unsigned exp_high;
        int unsigned exp_duty;
    } vec_t;

    typedef struct { int unsigned period; int unsigned high; int unsigned at; } meas_exp_t;
    typedef struct { int unsigned count; int unsigned at; } burst_exp_t;
    typedef struct { int unsigned duty; int unsigned at; } duty_exp_t;

    vec_t       vecs[$];
    meas_exp_t  meas_q[$];
    burst_exp_t burst_q[$];
    duty_exp_t  duty_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    int unsigned mdl_period = 0;
    int unsigned mdl_high   = 0;
    int unsigned mdl_burst  = 0;
    int unsigned mdl_duty   = 0;

    meas_exp_t  me;
    burst_exp_t be;
    duty_exp_t  de;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hold pwm_in at val for len cycles; entered and left just after a posedge.
    task automatic seg(input logic val, input int unsigned len);
        pwm_in = val;
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " measPeriod"}, meas_period, mdl_period);
        check({tag, " measHigh"}, meas_high, mdl_high);
        check({tag, " burstCount"}, burst_count, mdl_burst);
        check({tag, " measDuty"}, meas_duty, mdl_duty);
    endtask

    task automatic check_drained(input string tag);
        check({tag, " measValid pending"}, meas_q.size(), 0);
        check({tag, " burstDone pending"}, burst_q.size(), 0);
        check({tag, " dutyValid pending"}, duty_q.size(), 0);
    endtask

    // Play vecs as one burst, then hold low until the burst times out.
    task automatic run_burst(input string tag);
        int unsigned n;
        n = vecs.size();
        for (int i = 0; i < int'(n); i++) begin
            if (i > 0) begin
                meas_q.push_back('{vecs[i-1].exp_period, vecs[i-1].exp_high, cyc + LAT});
                mdl_period = vecs[i-1].exp_period;
                mdl_high   = vecs[i-1].exp_high;
`ifdef DUTY_PCT_EN
                // A later measValid inside the divider latency supersedes this one.
                if (i == int'(n) - 1 || vecs[i].hi_len + vecs[i].lo_len > DIV_LAT) begin
                    duty_q.push_back('{vecs[i-1].exp_duty, cyc + LAT + DIV_LAT});
                    mdl_duty = vecs[i-1].exp_duty;
                end
`endif
            end
            seg(1'b1, vecs[i].hi_len);
            if (i == int'(n) - 1) begin
                mdl_burst = (n > 255) ? 255 : n;
                burst_q.push_back('{mdl_burst, cyc + LAT + TIMEOUT});
            end
            seg(1'b0, vecs[i].lo_len);
        end
        seg(1'b0, TIMEOUT + 40);
        check_drained(tag);
        check_outputs(tag);
    endtask

    // Scoreboard: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (meas_valid !== 1'b0) begin
                check("measValid expected", meas_q.size() != 0, 1);
                if (meas_q.size() != 0) begin
                    me = meas_q.pop_front();
                    check("measPeriod", meas_period, me.period);
                    check("measHigh", meas_high, me.high);
                    check("measValid cycle", cyc, me.at);
                end
            end
            if (burst_done !== 1'b0) begin
                check("burstDone expected", burst_q.size() != 0, 1);
                if (burst_q.size() != 0) begin
                    be = burst_q.pop_front();
                    check("burstCount", burst_count, be.count);
                    check("burstDone cycle", cyc, be.at);
                end
            end
            if (duty_valid !== 1'b0) begin
                check("dutyValid expected", duty_q.size() != 0, 1);
                if (duty_q.size() != 0) begin
                    de = duty_q.pop_front();
                    check("measDuty", meas_duty, de.duty);
                    check("dutyValid cycle", cyc, de.at);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset measValid", meas_valid, 0);
        check("reset burstDone", burst_done, 0);
        check("reset dutyValid", duty_valid, 0);
        rst    = 1'b0;
        enable = 1'b1;
        seg(1'b0, 5);
        check_outputs("post-reset");

        // 16-pulse burst of 128 high / 128 low, then idle.
        vecs.delete();
        for (int i = 0; i < 16; i++) vecs.push_back('{128, 128, 256, 128, 50});
        run_burst("burst16");

        // Minimum period, saturation, and back-to-back divider restart.
        vecs.delete();
        vecs.push_back('{1,   1,   2,    1,   50});
        vecs.push_back('{1,   1,   2,    1,   50});
        vecs.push_back('{2,   1,   3,    2,   66});
        vecs.push_back('{700, 700, 1023, 700, 68});
        vecs.push_back('{100, 200, 300,  100, 33});
        vecs.push_back('{6,   6,   12,   6,   50});
        vecs.push_back('{3,   4,   7,    3,   42});
        run_burst("edges");

        // Constant high after one rise: times out in HIGH with one pulse.
        mdl_burst = 1;
        burst_q.push_back('{1, cyc + LAT + TIMEOUT});
        seg(1'b1, TIMEOUT + 40);
        seg(1'b0, 20);
        check_drained("const-high");
        check_outputs("const-high");

        // Enable dropped mid-HIGH: no strobes, outputs hold.
        seg(1'b1, 20);
        enable = 1'b0;
        seg(1'b1, 30);
        seg(1'b0, 10);
        seg(1'b1, 10);
        seg(1'b0, 10);
        check_outputs("enable-low");
        enable = 1'b1;
        seg(1'b0, 5);

        // Reset asserted mid-LOW: outputs clear without a clock edge.
        seg(1'b1, 10);
        seg(1'b0, 10);
        rst = 1'b1;
        #1;
        mdl_period = 0;
        mdl_high   = 0;
        mdl_burst  = 0;
        mdl_duty   = 0;
        check_outputs("async-reset");
        check("async-reset measValid", meas_valid, 0);
        check("async-reset burstDone", burst_done, 0);
        seg(1'b0, 5);
        rst = 1'b0;
        seg(1'b0, TIMEOUT + 40);
        check_outputs("after-reset");
        check_drained("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
